// File: rtl/trap_sequencer_pkg.sv
// Shared core definitions: trap FSM state encodings, exception cause codes
// and the machine-mode CSR address list.
package trap_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FLUSH  = 3'd1,
        ST_VECTOR = 3'd2,
        ST_RETURN = 3'd3,
        ST_HALT   = 3'd4
    } trap_state_e;

    localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL          = 4'd2;
    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    localparam logic [15:0] TRAP_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/trap_sequencer.sv
// Trap/return sequencer: turns exceptions and MRET into flush, stall and
// redirect pulses, tracks handler occupancy and halts on a double fault.
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter logic [15:0] COUNT_RESET_VALUE = 16'h0000
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        exc_valid,
    input  logic [3:0]  exc_code,
    input  logic        mret,
    input  logic [31:0] mepc,
    input  logic [31:0] mtvec_base,
    input  logic        halt_clear,
    output logic        flush_fd,
    output logic        flush_xb,
    output logic        stall_fetch,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [3:0]  cause_q,
    output logic        in_handler,
    output logic        double_fault,
    output logic [15:0] trap_count
);

    trap_state_e state_q, state_d;
    logic [3:0]  cause_d;
    logic        in_handler_q, in_handler_d;
    logic        double_fault_q, double_fault_d;
    logic [15:0] trap_count_q, trap_count_d;
    logic [15:0] trap_count_inc;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        unused_mtvec_bits;

    // Direct mode only: the low two vector bits carry no meaning here.
    assign unused_mtvec_bits = ^mtvec_base[1:0];

    assign trap_count_inc = (trap_count_q == TRAP_COUNT_MAX) ? trap_count_q
                                                             : trap_count_q + 16'd1;

    always_comb begin
        state_d        = state_q;
        cause_d        = cause_q;
        in_handler_d   = in_handler_q;
        double_fault_d = double_fault_q;
        trap_count_d   = trap_count_q;
        redirect_pc_d  = redirect_pc_q;

        case (state_q)
            ST_IDLE: begin
                // Exception outranks a coincident MRET.
                if (exc_valid) begin
                    if (in_handler_q) begin
                        state_d        = ST_HALT;
                        double_fault_d = 1'b1;
                    end else begin
                        state_d      = ST_FLUSH;
                        cause_d      = exc_code;
                        trap_count_d = trap_count_inc;
                    end
                end else if (mret) begin
                    if (in_handler_q) begin
                        state_d       = ST_RETURN;
                        redirect_pc_d = mepc;
                    end else begin
                        state_d      = ST_FLUSH;
                        cause_d      = CAUSE_ILLEGAL;
                        trap_count_d = trap_count_inc;
                    end
                end
            end
            ST_FLUSH: begin
                redirect_pc_d = {mtvec_base[31:2], 2'b00};
                state_d       = ST_VECTOR;
            end
            ST_VECTOR: begin
                in_handler_d = 1'b1;
                state_d      = ST_IDLE;
            end
            ST_RETURN: begin
                in_handler_d = 1'b0;
                state_d      = ST_IDLE;
            end
            ST_HALT: begin
                if (halt_clear) begin
                    state_d        = ST_IDLE;
                    double_fault_d = 1'b0;
                    in_handler_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        flush_fd       = 1'b0;
        flush_xb       = 1'b0;
        stall_fetch    = 1'b0;
        redirect_valid = 1'b0;
        case (state_q)
            ST_FLUSH, ST_HALT: begin
                flush_fd    = 1'b1;
                flush_xb    = 1'b1;
                stall_fetch = 1'b1;
            end
            ST_VECTOR: begin
                redirect_valid = 1'b1;
                flush_fd       = 1'b1;
            end
            ST_RETURN: begin
                redirect_valid = 1'b1;
                flush_fd       = 1'b1;
                flush_xb       = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q        <= ST_IDLE;
            cause_q        <= 4'd0;
            in_handler_q   <= 1'b0;
            double_fault_q <= 1'b0;
            trap_count_q   <= COUNT_RESET_VALUE;
            redirect_pc_q  <= 32'd0;
        end else begin
            state_q        <= state_d;
            cause_q        <= cause_d;
            in_handler_q   <= in_handler_d;
            double_fault_q <= double_fault_d;
            trap_count_q   <= trap_count_d;
            redirect_pc_q  <= redirect_pc_d;
        end
    end

    assign redirect_pc  = redirect_pc_q;
    assign in_handler   = in_handler_q;
    assign double_fault = double_fault_q;
    assign trap_count   = trap_count_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer; a second instance with a preloaded
// trap counter exercises saturation.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        resetb;
    logic        exc_valid, mret, halt_clear;
    logic [3:0]  exc_code;
    logic [31:0] mepc, mtvec_base;
    logic        flush_fd, flush_xb, stall_fetch, redirect_valid;
    logic [31:0] redirect_pc;
    logic [3:0]  cause_q;
    logic        in_handler, double_fault;
    logic [15:0] trap_count;

    logic        s_exc_valid, s_mret;
    logic        s_flush_fd, s_flush_xb, s_stall_fetch, s_redirect_valid;
    logic [31:0] s_redirect_pc;
    logic [3:0]  s_cause_q;
    logic        s_in_handler, s_double_fault;
    logic [15:0] s_trap_count;

    int assert_count = 0;
    int fail_count   = 0;

    always #5 clk = ~clk;

    trap_sequencer dut (
        .clk(clk), .resetb(resetb), .exc_valid(exc_valid), .exc_code(exc_code),
        .mret(mret), .mepc(mepc), .mtvec_base(mtvec_base), .halt_clear(halt_clear),
        .flush_fd(flush_fd), .flush_xb(flush_xb), .stall_fetch(stall_fetch),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .cause_q(cause_q),
        .in_handler(in_handler), .double_fault(double_fault), .trap_count(trap_count)
    );

    trap_sequencer #(.COUNT_RESET_VALUE(16'hFFFE)) dut_sat (
        .clk(clk), .resetb(resetb), .exc_valid(s_exc_valid), .exc_code(4'd6),
        .mret(s_mret), .mepc(mepc), .mtvec_base(mtvec_base), .halt_clear(1'b0),
        .flush_fd(s_flush_fd), .flush_xb(s_flush_xb), .stall_fetch(s_stall_fetch),
        .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc), .cause_q(s_cause_q),
        .in_handler(s_in_handler), .double_fault(s_double_fault), .trap_count(s_trap_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic ev, input logic [3:0] code,
                                  input logic mr, input logic hc);
        exc_valid  = ev;
        exc_code   = code;
        mret       = mr;
        halt_clear = hc;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packs {flush_fd, flush_xb, stall_fetch, redirect_valid}.
    function automatic logic [31:0] ctl();
        return {28'd0, flush_fd, flush_xb, stall_fetch, redirect_valid};
    endfunction

    function automatic logic [31:0] s_ctl();
        return {28'd0, s_flush_fd, s_flush_xb, s_stall_fetch, s_redirect_valid};
    endfunction

    initial begin
        resetb      = 1'b0;
        mepc        = 32'h0000_0040;
        mtvec_base  = 32'h0000_0103;
        s_exc_valid = 1'b0;
        s_mret      = 1'b0;
        apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        tick();
        check_output("reset_ctl", ctl(), 32'h0);
        check_output("reset_count", {16'd0, trap_count}, 32'h0);
        check_output("reset_cause", {28'd0, cause_q}, 32'h0);
        check_output("reset_pc", redirect_pc, 32'h0);
        check_output("reset_flags", {30'd0, in_handler, double_fault}, 32'h0);
        resetb = 1'b1;
        tick();
        check_output("idle_ctl", ctl(), 32'h0);

        $display("[TB] single trap");
        apply_stimulus(1'b1, 4'd2, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0);
        check_output("trap_flush_ctl", ctl(), 32'hE);
        check_output("trap_cause", {28'd0, cause_q}, 32'h2);
        check_output("trap_count1", {16'd0, trap_count}, 32'h1);
        tick();
        check_output("trap_vector_ctl", ctl(), 32'h9);
        check_output("trap_vector_pc", redirect_pc, 32'h0000_0100);
        tick();
        check_output("trap_idle_ctl", ctl(), 32'h0);
        check_output("trap_in_handler", {31'd0, in_handler}, 32'h1);

        $display("[TB] return");
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0);
        tick();
        apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0);
        check_output("ret_ctl", ctl(), 32'hD);
        check_output("ret_pc", redirect_pc, 32'h0000_0040);
        tick();
        check_output("ret_in_handler", {31'd0, in_handler}, 32'h0);
        check_output("ret_idle_ctl", ctl(), 32'h0);

        $display("[TB] double fault");
        apply_stimulus(1'b1, 4'd0, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        tick();
        check_output("df_handler_entered", {31'd0, in_handler}, 32'h1);
        check_output("df_count2", {16'd0, trap_count}, 32'h2);
        apply_stimulus(1'b1, 4'd6, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_output("df_halt_ctl", ctl(), 32'hE);
            check_output("df_flag", {31'd0, double_fault}, 32'h1);
            tick();
        end
        check_output("df_count_held", {16'd0, trap_count}, 32'h2);
        check_output("df_cause_held", {28'd0, cause_q}, 32'h0);
        apply_stimulus(1'b0, 4'd0, 1'b0, 1'b1);
        tick();
        apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0);
        check_output("df_clear_ctl", ctl(), 32'h0);
        check_output("df_clear_flags", {30'd0, in_handler, double_fault}, 32'h0);

        $display("[TB] simultaneous exception and mret");
        apply_stimulus(1'b1, 4'd4, 1'b1, 1'b0);
        tick();
        check_output("sim_flush_ctl", ctl(), 32'hE);
        check_output("sim_cause", {28'd0, cause_q}, 32'h4);
        check_output("sim_count3", {16'd0, trap_count}, 32'h3);
        tick();
        apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0);
        check_output("sim_vector_ctl", ctl(), 32'h9);
        check_output("sim_vector_pc", redirect_pc, 32'h0000_0100);
        tick();
        check_output("sim_idle_flags", {30'd0, in_handler, double_fault}, 32'h2);
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0);
        tick();
        apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0);
        check_output("sim_ret_ctl", ctl(), 32'hD);
        tick();

        $display("[TB] mret outside handler");
        mtvec_base = 32'h0000_2002;
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0);
        tick();
        apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0);
        check_output("ill_flush_ctl", ctl(), 32'hE);
        check_output("ill_cause", {28'd0, cause_q}, 32'h2);
        check_output("ill_count4", {16'd0, trap_count}, 32'h4);
        tick();
        check_output("ill_vector_pc", redirect_pc, 32'h0000_2000);
        tick();
        check_output("ill_in_handler", {31'd0, in_handler}, 32'h1);
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0);
        tick();
        apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0);
        tick();

        $display("[TB] reset during flush");
        apply_stimulus(1'b1, 4'd6, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0);
        check_output("rst_pre_flush_ctl", ctl(), 32'hE);
        resetb = 1'b0;
        #1;
        check_output("rst_ctl", ctl(), 32'h0);
        check_output("rst_count", {16'd0, trap_count}, 32'h0);
        check_output("rst_cause", {28'd0, cause_q}, 32'h0);
        check_output("rst_pc", redirect_pc, 32'h0);
        check_output("rst_flags", {30'd0, in_handler, double_fault}, 32'h0);
        tick();
        check_output("rst_hold_ctl", ctl(), 32'h0);
        resetb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("rst_after_ctl", ctl(), 32'h0);
        end

        $display("[TB] counter saturation");
        check_output("sat_preload", {16'd0, s_trap_count}, 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) begin
            s_exc_valid = 1'b1;
            tick();
            s_exc_valid = 1'b0;
            check_output("sat_flush_ctl", s_ctl(), 32'hE);
            check_output("sat_count", {16'd0, s_trap_count}, 32'h0000_FFFF);
            tick();
            tick();
            check_output("sat_in_handler", {31'd0, s_in_handler}, 32'h1);
            s_mret = 1'b1;
            tick();
            s_mret = 1'b0;
            check_output("sat_ret_ctl", s_ctl(), 32'hD);
            tick();
        end
        check_output("sat_final", {16'd0, s_trap_count}, 32'h0000_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 resetb  input  1  asynchronous active-low reset.
REQ-003 exc_valid  input  1  exception request from the CSR/exception unit (illegal or misaligned), already qualified by non-bubble.
REQ-004 exc_code  input  4  cause code accompanying exc_valid: 0 instr-misaligned, 2 illegal, 4 load-misaligned, 6 store-misaligned.
REQ-005 mret  input  1  MRET committing in XB stage (non-bubble).
REQ-006 mepc  input  32  current mepc CSR value.
REQ-007 mtvec_base  input  32  trap vector; bits [1:0] ignored (direct mode only).
REQ-008 halt_clear  input  1  debug/testbench release from the double-fault halt.
REQ-009 flush_fd, flush_xb  output  1 each  kill the instruction in that stage.
REQ-010 stall_fetch  output  1  hold the fetch PC.
REQ-011 redirect_valid  output  1  load redirect_pc into the PC this cycle.
REQ-012 redirect_pc  output  32  redirect target.
REQ-013 cause_q  output  4  latched cause of the last accepted trap.
REQ-014 in_handler  output  1  a trap handler is executing.
REQ-015 double_fault  output  1  sticky halt indication.
REQ-016 trap_count  output  16  number of accepted traps.

Function
REQ-017 The FSM SHALL have the states IDLE, FLUSH, VECTOR, RETURN and HALT; all control outputs SHALL be Moore outputs decoded from the registered state.
REQ-018 IDLE: exc_valid with in_handler=0 -> FLUSH; latch cause_q=exc_code; trap_count+1, saturating at 16'hFFFF.
REQ-019 IDLE: exc_valid with in_handler=1 -> HALT; set double_fault; trap_count and cause_q unchanged.
REQ-020 IDLE: mret with in_handler=1 and exc_valid=0 -> RETURN; latch redirect_pc=mepc.
REQ-021 IDLE: mret with in_handler=0 SHALL be handled as illegal: -> FLUSH with cause_q=2, trap_count+1.
REQ-022 When exc_valid and mret are asserted in the same cycle, the exception SHALL win.
REQ-023 FLUSH (1 cycle): flush_fd=flush_xb=stall_fetch=1; latch redirect_pc={mtvec_base[31:2],2'b00}; -> VECTOR.
REQ-024 VECTOR (1 cycle): redirect_valid=1 and flush_fd=1; set in_handler=1; -> IDLE.
REQ-025 RETURN (1 cycle): redirect_valid=1, flush_fd=1, flush_xb=1; clear in_handler; -> IDLE.
REQ-026 HALT: flush_fd=flush_xb=stall_fetch=1 every cycle; on halt_clear -> IDLE and clear double_fault and in_handler.
REQ-027 exc_valid and mret SHALL be ignored in FLUSH, VECTOR and RETURN.
REQ-028 Latency: a request sampled at edge N SHALL give flush at cycle N+1 and redirect_valid at cycle N+2 for a trap; redirect_valid at N+1 for MRET.
REQ-029 In IDLE all flush, stall and redirect outputs SHALL be 0.

Reset
REQ-030 Reset SHALL force: state IDLE, all control outputs 0, in_handler=0, double_fault=0, trap_count=0, cause_q=0, redirect_pc=0.
REQ-031 Reset asserted in any state, including HALT or mid-FLUSH, SHALL abort the sequence immediately with no redirect issued.

Structure
REQ-032 The state encodings and the exception cause codes (0/2/4/6) SHALL live in the shared core include file, alongside the CSR address list.
REQ-033 No sub-module; the saturating trap counter SHALL be inline.

Verification
REQ-034 The bench SHALL cover a single trap: mtvec_base=32'h0000_0103, exc_valid with exc_code=2 -> flush at N+1; redirect_pc=32'h0000_0100 with redirect_valid at N+2; in_handler=1; trap_count=1.
REQ-035 The bench SHALL cover trap then return: mepc=32'h0000_0040, mret in handler -> redirect_valid with redirect_pc=32'h0000_0040 one cycle later; in_handler=0.
REQ-036 The bench SHALL cover a double fault: exc_valid while in_handler=1 -> HALT; double_fault=1 and flush/stall held until halt_clear; then IDLE with double_fault=0.
REQ-037 The bench SHALL cover simultaneous events: exc_valid, exc_code=4, and mret together with in_handler=0 -> FLUSH with cause_q=4 and no RETURN.
REQ-038 The bench SHALL cover counter saturation: preload trap_count to 16'hFFFE and apply 3 traps, each followed by mret -> trap_count=16'hFFFF.
REQ-039 The bench SHALL cover reset mid-FLUSH: resetb low during FLUSH -> all outputs 0 and redirect_valid never asserted.
